// File: rtl/alu_share_ctrl_if.sv
// Requester/consumer bundle for alu_share_ctrl: two operand ports,
// the grant pulses and the result handshake.
interface alu_share_ctrl_if;
    logic       req0;
    logic       req1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic [2:0] op0;
    logic [2:0] op1;
    logic       grant0;
    logic       grant1;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic       res_id;
    logic       busy;
    logic [7:0] op_count;

    modport master (
        output req0, req1, a0, b0, a1, b1, op0, op1, res_ready,
        input  grant0, grant1, res_valid, result, res_id, busy, op_count
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, op0, op1, res_ready,
        output grant0, grant1, res_valid, result, res_id, busy, op_count
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one 4-bit ALU between two requesters;
// result is registered and held behind a valid/ready handshake.
module alu_share_ctrl (
    input  logic             clk,
    input  logic             resetn,
    alu_share_ctrl_if.slave  bus
);
    localparam int unsigned OPND_W = 4;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned RES_W  = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [OPND_W-1:0]   a_q, a_d;
    logic [OPND_W-1:0]   b_q, b_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic                id_q, id_d;
    logic                last_q, last_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic                res_id_q, res_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                grant0_c, grant1_c;
    logic                busy_c, valid_c;
    logic                handshake_c;

    function automatic logic [RES_W-1:0] alu_f(
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b,
        input logic [OP_W-1:0]   op
    );
        logic [RES_W-1:0] r;
        r = '0;
        unique case (op)
            3'b111:  r = RES_W'(5'(a) + 5'(b));
            3'b110:  r = RES_W'(a) + RES_W'(b);
            3'b101:  r = {~(a | b), ~(a & b)};
            3'b100:  r = ((a != '0) || (b != '0)) ? 8'hC0 : 8'h00;
            3'b011:  r = (($countones(a) == 2) && ($countones(b) == 3)) ? 8'h3F : 8'h00;
            3'b010:  r = {b, ~a};
            3'b001:  r = {a ^ b, ~(a ^ b)};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant0_c || grant1_c) state_d = S_EXEC;
            S_EXEC:  state_d = S_HOLD;
            S_HOLD:  if (bus.res_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; grants are gated by reset so none escape while it is held
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        busy_c   = (state_q != S_IDLE);
        valid_c  = (state_q == S_HOLD);
        if ((state_q == S_IDLE) && resetn) begin
            grant0_c = bus.req0 && (!bus.req1 || last_q);
            grant1_c = bus.req1 && (!bus.req0 || !last_q);
        end
    end

    assign handshake_c = valid_c && bus.res_ready;

    // Operand capture, execute and completion counting
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        id_d     = id_q;
        last_d   = last_q;
        result_d = result_q;
        res_id_d = res_id_q;
        cnt_d    = cnt_q;
        if (grant0_c) begin
            a_d    = bus.a0;
            b_d    = bus.b0;
            op_d   = bus.op0;
            id_d   = 1'b0;
            last_d = 1'b0;
        end else if (grant1_c) begin
            a_d    = bus.a1;
            b_d    = bus.b1;
            op_d   = bus.op1;
            id_d   = 1'b1;
            last_d = 1'b1;
        end
        if (state_q == S_EXEC) begin
            result_d = alu_f(a_q, b_q, op_q);
            res_id_d = id_q;
        end
        if (handshake_c) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            result_q <= '0;
            res_id_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            id_q     <= id_d;
            last_q   <= last_d;
            result_q <= result_d;
            res_id_q <= res_id_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.grant0    = grant0_c;
    assign bus.grant1    = grant1_c;
    assign bus.busy      = busy_c;
    assign bus.res_valid = valid_c;
    assign bus.result    = result_q;
    assign bus.res_id    = res_id_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl; inputs driven and outputs sampled
// just after the falling edge.
module tb_alu_share_ctrl;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    alu_share_ctrl_if bus();

    alu_share_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_cnt;

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic gnt(input bit port);
        return port ? bus.grant1 : bus.grant0;
    endfunction

    task automatic drive_port(input bit port, input logic [3:0] a, input logic [3:0] b,
                              input logic [2:0] op, input logic req);
        if (port) begin
            bus.a1 = a; bus.b1 = b; bus.op1 = op; bus.req1 = req;
        end else begin
            bus.a0 = a; bus.b0 = b; bus.op0 = op; bus.req0 = req;
        end
    endtask

    task automatic drop_req(input bit port);
        if (port) bus.req1 = 1'b0;
        else      bus.req0 = 1'b0;
    endtask

    task automatic wait_grant(input bit port);
        int n;
        n = 0;
        while (!gnt(port) && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_val("grant", 8'(gnt(port)), 8'h01);
    endtask

    // Full transaction with res_ready already high: grant, EXEC, HOLD, IDLE
    task automatic run_txn(input bit port, input logic [3:0] a, input logic [3:0] b,
                           input logic [2:0] op, input logic [7:0] exp_res);
        drive_port(port, a, b, op, 1'b1);
        #1;
        wait_grant(port);
        @(negedge clk);
        drop_req(port);
        #1;
        check_val("exec_busy", 8'(bus.busy), 8'h01);
        check_val("exec_valid", 8'(bus.res_valid), 8'h00);
        @(negedge clk); #1;
        check_val("hold_valid", 8'(bus.res_valid), 8'h01);
        check_val("result", bus.result, exp_res);
        check_val("res_id", 8'(bus.res_id), 8'(port));
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 8'd1;
        check_val("op_count", bus.op_count, exp_cnt);
        check_val("idle_valid", 8'(bus.res_valid), 8'h00);
    endtask

    logic [7:0] sweep_exp [8];
    bit         exp_id;

    initial begin
        // Expected results for a=5, b=A, opcodes 000..111 from the opcode map
        sweep_exp[0] = 8'h00; sweep_exp[1] = 8'hF0; sweep_exp[2] = 8'hAA; sweep_exp[3] = 8'h00;
        sweep_exp[4] = 8'hC0; sweep_exp[5] = 8'h0F; sweep_exp[6] = 8'h0F; sweep_exp[7] = 8'h0F;

        resetn        = 1'b0;
        bus.res_ready = 1'b1;
        drive_port(1'b0, 4'd7, 4'd9, 3'b111, 1'b1);
        drive_port(1'b1, 4'd0, 4'd0, 3'b000, 1'b1);
        exp_cnt = 8'd0;

        // Reset held with both requests high
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_grant0", 8'(bus.grant0), 8'h00);
        check_val("rst_grant1", 8'(bus.grant1), 8'h00);
        check_val("rst_valid", 8'(bus.res_valid), 8'h00);
        check_val("rst_result", bus.result, 8'h00);
        check_val("rst_count", bus.op_count, 8'h00);
        check_val("rst_busy", 8'(bus.busy), 8'h00);
        check_val("rst_res_id", 8'(bus.res_id), 8'h00);

        // Release: port 0 wins the first tie; its 7+9 add completes
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_val("first_grant0", 8'(bus.grant0), 8'h01);
        check_val("first_grant1", 8'(bus.grant1), 8'h00);
        @(negedge clk);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        check_val("add_exec_valid", 8'(bus.res_valid), 8'h00);
        @(negedge clk); #1;
        check_val("add_valid", 8'(bus.res_valid), 8'h01);
        check_val("add_result", bus.result, 8'h10);
        check_val("add_res_id", 8'(bus.res_id), 8'h00);
        @(negedge clk); #1;
        exp_cnt = 8'd1;
        check_val("add_count", bus.op_count, exp_cnt);

        // Opcode sweep on port 1
        for (int i = 0; i < 8; i++)
            run_txn(1'b1, 4'h5, 4'hA, 3'(i), sweep_exp[i]);

        // Backpressure on port 0 while port 1 waits
        bus.res_ready = 1'b0;
        drive_port(1'b0, 4'b0011, 4'b0111, 3'b011, 1'b1);
        #1;
        wait_grant(1'b0);
        @(negedge clk);
        bus.req0 = 1'b0;
        drive_port(1'b1, 4'h0, 4'h0, 3'b000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check_val("bp_valid", 8'(bus.res_valid), 8'h01);
            check_val("bp_result", bus.result, 8'h3F);
            check_val("bp_no_grant", 8'(bus.grant1), 8'h00);
        end
        check_val("bp_count", bus.op_count, exp_cnt);
        bus.res_ready = 1'b1;
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 8'd1;
        check_val("bp_hs_count", bus.op_count, exp_cnt);
        check_val("bp_idle_valid", 8'(bus.res_valid), 8'h00);
        check_val("bp_idle_busy", 8'(bus.busy), 8'h00);
        check_val("bp_next_grant1", 8'(bus.grant1), 8'h01);
        @(negedge clk);
        bus.req1 = 1'b0;
        @(negedge clk); #1;
        check_val("bp_p1_result", bus.result, 8'h00);
        check_val("bp_p1_res_id", 8'(bus.res_id), 8'h01);
        @(negedge clk); #1;
        exp_cnt = exp_cnt + 8'd1;
        check_val("bp_p1_count", bus.op_count, exp_cnt);

        // Fairness: both ports requesting continuously, grants every 3 cycles
        drive_port(1'b0, 4'hF, 4'h0, 3'b101, 1'b1);
        drive_port(1'b1, 4'hF, 4'h0, 3'b101, 1'b1);
        #1;
        exp_id = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("fair_grant0", 8'(bus.grant0), 8'(!exp_id));
            check_val("fair_grant1", 8'(bus.grant1), 8'(exp_id));
            @(negedge clk);
            if (i == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            #1;
            @(negedge clk); #1;
            check_val("fair_result", bus.result, 8'h0F);
            check_val("fair_res_id", 8'(bus.res_id), 8'(exp_id));
            @(negedge clk); #1;
            exp_cnt = exp_cnt + 8'd1;
            check_val("fair_count", bus.op_count, exp_cnt);
            exp_id = !exp_id;
        end

        // Reset during EXEC discards the operation; request is re-granted
        drive_port(1'b0, 4'd1, 4'd2, 3'b111, 1'b1);
        #1;
        wait_grant(1'b0);
        @(negedge clk); #1;
        check_val("mid_exec_busy", 8'(bus.busy), 8'h01);
        resetn = 1'b0;
        #1;
        check_val("mid_valid", 8'(bus.res_valid), 8'h00);
        check_val("mid_busy", 8'(bus.busy), 8'h00);
        check_val("mid_count", bus.op_count, 8'h00);
        check_val("mid_result", bus.result, 8'h00);
        check_val("mid_grant0", 8'(bus.grant0), 8'h00);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_val("mid_regrant", 8'(bus.grant0), 8'h01);
        @(negedge clk);
        bus.req0 = 1'b0;
        @(negedge clk); #1;
        check_val("mid_result2", bus.result, 8'h03);
        check_val("mid_valid2", 8'(bus.res_valid), 8'h01);
        @(negedge clk); #1;
        exp_cnt = 8'd1;
        check_val("mid_count2", bus.op_count, exp_cnt);

        // Counter wrap 255 -> 0 with port 0 requesting back to back
        drive_port(1'b0, 4'h0, 4'h0, 3'b000, 1'b1);
        begin
            int n;
            n = 0;
            while (bus.op_count != 8'hFF && n < 2000) begin
                @(negedge clk); #1;
                n++;
            end
        end
        check_val("wrap_255", bus.op_count, 8'hFF);
        check_val("wrap_grant", 8'(bus.grant0), 8'h01);
        repeat (3) @(negedge clk);
        #1;
        check_val("wrap_0", bus.op_count, 8'h00);
        bus.req0 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
